// File: rtl/matrix_multiplier.sv
// matrix_multiplier: walks C = A*B over two N x N operand matrices held by the
// loader, one output element at a time in row-major order. Each element asks
// the loader for A row i and B column j, waits RD_LAT cycles, registers the N
// products, registers their sum and offers it on a valid/ready output port.
//
// Optional feature macro: MATMUL_SIGNED_EN
//   defined   -> elements are two's-complement signed, out_data sign-extended
//   undefined -> elements unsigned, out_data zero-extended (default build)
//
// Output handshake: a result transfers on a rising edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_valid, out_data,
// out_row and out_col hold until that edge. out_ready is ignored while
// out_valid is 0.
module matrix_multiplier #(
   parameter int N      = 32,
   parameter int ELEM_W = 8,
   parameter int RD_LAT = 1,
   parameter int ACC_W  = 21
) (
   input  logic                   inter_refclk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic [$clog2(N)-1:0]   requested_a_row,
   output logic [$clog2(N)-1:0]   requested_b_col,
   input  logic [N*ELEM_W-1:0]    a_row_in,
   input  logic [N*ELEM_W-1:0]    b_col_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_data,
   output logic [$clog2(N)-1:0]   out_row,
   output logic [$clog2(N)-1:0]   out_col,
   output logic                   busy,
   output logic                   done
);

   localparam int AW    = $clog2(N);
   localparam int PW    = 2 * ELEM_W;
   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_MUL,
      S_SUM,
      S_OUT,
      S_DONE
   } state_t;

   // State is kept as a named enum so checkers can bind to it hierarchically.
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]      i_q, i_d;
   logic [AW-1:0]      j_q, j_d;
   logic [N*ELEM_W-1:0] a_q, a_d;
   logic [N*ELEM_W-1:0] b_q, b_d;
   logic [PW-1:0]      prod_q [N];
   logic [PW-1:0]      prod_d [N];
   logic [PW-1:0]      prod_calc [N];
   logic [ACC_W-1:0]   sum_calc;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   out_data_q, out_data_d;
   logic [AW-1:0]      out_row_q, out_row_d;
   logic [AW-1:0]      out_col_q, out_col_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               last_elem;

   // Widen one element to product width; the low PW bits of the product are
   // then correct for both unsigned and two's-complement operands.
   function automatic logic [PW-1:0] ext_elem(input logic [ELEM_W-1:0] e);
`ifdef MATMUL_SIGNED_EN
      return {{ELEM_W{e[ELEM_W-1]}}, e};
`else
      return {{ELEM_W{1'b0}}, e};
`endif
   endfunction

   // Widen one product to result width before accumulation so the sum never
   // truncates.
   function automatic logic [ACC_W-1:0] ext_prod(input logic [PW-1:0] p);
`ifdef MATMUL_SIGNED_EN
      return {{(ACC_W-PW){p[PW-1]}}, p};
`else
      return {{(ACC_W-PW){1'b0}}, p};
`endif
   endfunction

   assign last_elem = (i_q == AW'(N - 1)) && (j_q == AW'(N - 1));

   // Element-wise products of the sampled A row and B column.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         prod_calc[k] = ext_elem(a_q[k*ELEM_W +: ELEM_W]) *
                        ext_elem(b_q[k*ELEM_W +: ELEM_W]);
      end
   end

   // Sum of the registered products; synthesis shapes this into a tree.
   always_comb begin
      sum_calc = '0;
      for (int k = 0; k < N; k++) begin
         sum_calc = sum_calc + ext_prod(prod_q[k]);
      end
   end

   // Next-state and next-output computation for the element walk.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      i_d         = i_q;
      j_d         = j_q;
      a_d         = a_q;
      b_d         = b_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      for (int k = 0; k < N; k++) begin
         prod_d[k] = prod_q[k];
      end

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = S_REQ;
               busy_d  = 1'b1;
               i_d     = '0;
               j_d     = '0;
            end
         end
         S_REQ: begin
            cnt_d   = CNT_W'(RD_LAT - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               // Loader data has settled for the current addresses.
               a_d     = a_row_in;
               b_d     = b_col_in;
               state_d = S_MUL;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_MUL: begin
            for (int k = 0; k < N; k++) begin
               prod_d[k] = prod_calc[k];
            end
            state_d = S_SUM;
         end
         S_SUM: begin
            out_data_d  = sum_calc;
            out_row_d   = i_q;
            out_col_d   = j_q;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (last_elem) begin
                  i_d     = '0;
                  j_d     = '0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  if (j_q == AW'(N - 1)) begin
                     j_d = '0;
                     i_d = i_q + 1'b1;
                  end else begin
                     j_d = j_q + 1'b1;
                  end
                  state_d = S_REQ;
               end
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any run in progress.
   always_ff @(posedge inter_refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         i_q         <= '0;
         j_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int k = 0; k < N; k++) begin
            prod_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         i_q         <= i_d;
         j_q         <= j_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         for (int k = 0; k < N; k++) begin
            prod_q[k] <= prod_d[k];
         end
      end
   end

   assign requested_a_row = i_q;
   assign requested_b_col = j_q;
   assign out_valid       = out_valid_q;
   assign out_data        = out_data_q;
   assign out_row         = out_row_q;
   assign out_col         = out_col_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_matrix_multiplier.sv
// Bench for matrix_multiplier: a loader model with RD_LAT latency feeds rows
// and columns from two matrices; every result is compared with C = A*B
// computed directly from those matrices.
module tb_matrix_multiplier;

   localparam int N      = 32;
   localparam int ELEM_W = 8;
   localparam int RD_LAT = 1;
   localparam int ACC_W  = 21;
   localparam int AW     = $clog2(N);

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic [AW-1:0]        requested_a_row;
   logic [AW-1:0]        requested_b_col;
   logic [N*ELEM_W-1:0]  a_row_in;
   logic [N*ELEM_W-1:0]  b_col_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_W-1:0]     out_data;
   logic [AW-1:0]        out_row;
   logic [AW-1:0]        out_col;
   logic                 busy;
   logic                 done;

   logic [ELEM_W-1:0]    ma [N][N];
   logic [ELEM_W-1:0]    mb [N][N];

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   matrix_multiplier #(
      .N(N), .ELEM_W(ELEM_W), .RD_LAT(RD_LAT), .ACC_W(ACC_W)
   ) dut (
      .inter_refclk    (clk),
      .rst_n           (rst_n),
      .start           (start),
      .requested_a_row (requested_a_row),
      .requested_b_col (requested_b_col),
      .a_row_in        (a_row_in),
      .b_col_in        (b_col_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_row         (out_row),
      .out_col         (out_col),
      .busy            (busy),
      .done            (done)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Loader model: one register stage (RD_LAT = 1) from address to data.
   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         a_row_in[k*ELEM_W +: ELEM_W] <= ma[requested_a_row][k];
         b_col_in[k*ELEM_W +: ELEM_W] <= mb[k][requested_b_col];
      end
   end

   // Count done pulses as seen between edges.
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: C[i][j] as a plain dot product of the stored matrices.
   function automatic logic [ACC_W-1:0] model_c(input int i, input int j);
      int s;
      s = 0;
      for (int k = 0; k < N; k++) begin
`ifdef MATMUL_SIGNED_EN
         s += int'($signed(ma[i][k])) * int'($signed(mb[k][j]));
`else
         s += int'(ma[i][k]) * int'(mb[k][j]);
`endif
      end
      return ACC_W'(s);
   endfunction

   // kind 0: A=identity, B=3; 1: diag 0 / off-diag FF; 2: all FF; 3: random
   task automatic fill(input int kind);
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            case (kind)
               0: begin ma[r][c] = (r == c) ? 8'd1 : 8'd0; mb[r][c] = 8'd3; end
               1: begin ma[r][c] = (r == c) ? 8'h00 : 8'hFF; mb[r][c] = ma[r][c]; end
               2: begin ma[r][c] = 8'hFF; mb[r][c] = 8'hFF; end
               default: begin
                  ma[r][c] = 8'($urandom_range(0, 255));
                  mb[r][c] = 8'($urandom_range(0, 255));
               end
            endcase
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_a_row"}, requested_a_row, 0);
      check({tag, "_b_col"}, requested_b_col, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_row"}, out_row, 0);
      check({tag, "_col"}, out_col, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   // Runs one full walk. mode 0: ready tied 1; 1: random ready; 2: 5 stall
   // cycles on element (0,1); 3: random start pulses while busy; 4: stop at
   // element (3,7) for an external reset.
   task automatic run_matrix(input int mode, output logic [ACC_W-1:0] obs00,
                             output logic [ACC_W-1:0] obs01);
      int cyc, e, wait_cyc, first_valid, done_before, stall, ei, ej;
      logic abort;
      obs00 = '0;
      obs01 = '0;
      abort = 1'b0;
      stall = 0;
      e = 0;
      wait_cyc = 0;
      first_valid = -1;
      done_before = done_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (e < N*N && wait_cyc < 200 && !abort) begin
         case (mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (out_valid && e == 1 && stall < 5) begin
                  out_ready = 1'b0;
                  stall++;
               end else begin
                  out_ready = 1'b1;
               end
            end
            3: begin
               out_ready = 1'b1;
               start = ($urandom_range(0, 5) == 0);
            end
            default: out_ready = 1'b1;
         endcase
         if (mode == 4 && out_valid && e == 3*N + 7) begin
            abort = 1'b1;
         end else if (out_valid) begin
            ei = e / N;
            ej = e % N;
            if (first_valid < 0) first_valid = cyc;
            check("out_row", out_row, ei);
            check("out_col", out_col, ej);
            check("out_data", out_data, model_c(ei, ej));
            check("req_a_row", requested_a_row, ei);
            check("req_b_col", requested_b_col, ej);
            if (e == 0) obs00 = out_data;
            if (e == 1) obs01 = out_data;
            if (out_ready) begin
               e++;
               wait_cyc = 0;
            end
         end else begin
            wait_cyc++;
         end
         if (!abort) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (abort) return;
      check("result_count", e, N*N);
      // Start accepted at edge P0; out_valid rises at P0+RD_LAT+3 and is
      // first seen on the falling edge after it, counted from 1 after P0.
      check("first_latency", first_valid, RD_LAT + 4);
      if (mode == 2) check("stall_cycles", stall, 5);
      repeat (3) @(negedge clk);
      check("done_pulses", done_cnt - done_before, 1);
      check("busy_after", busy, 0);
      check("valid_after", out_valid, 0);
      check("a_row_after", requested_a_row, 0);
      check("b_col_after", requested_b_col, 0);
   endtask

   initial begin
      logic [ACC_W-1:0] o00, o01;
      int done_snap;

      // Test 1: reset drives outputs low immediately; idle until start.
      rst_n = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      fill(0);
      #3;
      check_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_zero("idle");

      // Test 2: identity times all-3.
      fill(0);
      run_matrix(0, o00, o01);
      check("ident_c00", o00, 3);

      // Test 3: diag 0 / off-diag FF.
      fill(1);
      run_matrix(0, o00, o01);
`ifdef MATMUL_SIGNED_EN
      check("diag_c00", o00, 31);
      check("diag_c01", o01, 30);
`else
      check("diag_c00", o00, 2015775);
      check("diag_c01", o01, 1950750);
`endif

      // Test 4: all FF, worst case without overflow.
      fill(2);
      run_matrix(0, o00, o01);
`ifdef MATMUL_SIGNED_EN
      check("allff_c00", o00, 32);
`else
      check("allff_c00", o00, 2080800);
`endif

      // Random operands with random backpressure.
      fill(3);
      run_matrix(1, o00, o01);

      // Test 5: directed 5-cycle stall at (0,1).
      fill(3);
      run_matrix(2, o00, o01);

      // Test 6a: start pulses during a run are ignored.
      fill(3);
      run_matrix(3, o00, o01);

      // Test 6b: reset at element (3,7), then a clean restart.
      fill(3);
      done_snap = done_cnt;
      run_matrix(4, o00, o01);
      rst_n = 1'b0;
      #1;
      check_zero("midrun_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("no_done_on_reset", done_cnt - done_snap, 0);
      check("busy_after_reset", busy, 0);
      run_matrix(0, o00, o01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
